// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request/ready handshake, redirect/squash
// handling and the IF/ID register with a one-entry skid buffer.
module fetch_stage #(
  parameter int                    PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_stall,
  input  logic                in_branch_taken,
  input  logic [PC_WIDTH-1:0] in_branch_addr,
  input  logic                in_is_jump,
  input  logic [31:0]         in_jump_addr,
  input  logic                in_imem_ready,
  input  logic [31:0]         in_imem_data,
  output logic                out_imem_req,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [31:0]         out_inst,
  output logic                out_inst_valid,
  output logic [PC_WIDTH-1:0] out_inst_pc,
  output logic [PC_WIDTH-1:0] out_next_pc,
  output logic                out_flush
);

  typedef enum logic [1:0] {IDLE, BUSY, SQUASH} state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_d, pc_inc, target;
  logic [PC_WIDTH-1:0] saved_target, saved_d;
  logic                redirect, deliver;
  logic                skid_valid;
  logic [31:0]         skid_inst;
  logic [PC_WIDTH-1:0] skid_pc;

  // Jump wins over branch when both arrive together.
  assign redirect = in_is_jump | in_branch_taken;
  assign target   = in_is_jump ? in_jump_addr[PC_WIDTH-1:0] : in_branch_addr;
  assign pc_inc   = out_pc + PC_WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      out_pc       <= RESET_PC;
      saved_target <= '0;
    end else begin
      state_q      <= state_d;
      out_pc       <= pc_d;
      saved_target <= saved_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = out_pc;
    saved_d      = saved_target;
    deliver      = 1'b0;
    out_imem_req = 1'b0;
    case (state_q)
      IDLE: begin
        out_imem_req = ~in_stall & ~skid_valid & ~redirect;
        if (redirect) begin
          pc_d = target;
        end else if (out_imem_req) begin
          if (in_imem_ready) begin
            deliver = 1'b1;
            pc_d    = pc_inc;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        out_imem_req = 1'b1;
        if (in_imem_ready) begin
          state_d = IDLE;
          if (redirect) begin
            pc_d = target;
          end else begin
            deliver = 1'b1;
            pc_d    = pc_inc;
          end
        end else if (redirect) begin
          saved_d = target;
          state_d = SQUASH;
        end
      end
      SQUASH: begin
        // Outstanding response is wrong-path; the newest redirect wins.
        out_imem_req = 1'b1;
        if (in_imem_ready) begin
          state_d = IDLE;
          pc_d    = redirect ? target : saved_target;
        end else if (redirect) begin
          saved_d = target;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_inst       <= '0;
      out_inst_valid <= 1'b0;
      out_inst_pc    <= '0;
      out_next_pc    <= '0;
      out_flush      <= 1'b0;
      skid_valid     <= 1'b0;
      skid_inst      <= '0;
      skid_pc        <= '0;
    end else begin
      out_flush <= redirect;
      if (redirect) begin
        out_inst_valid <= 1'b0;
        skid_valid     <= 1'b0;
      end else if (deliver && !in_stall) begin
        out_inst       <= in_imem_data;
        out_inst_valid <= 1'b1;
        out_inst_pc    <= out_pc;
        out_next_pc    <= pc_inc;
      end else if (deliver) begin
        skid_inst  <= in_imem_data;
        skid_pc    <= out_pc;
        skid_valid <= 1'b1;
      end else if (!in_stall) begin
        if (skid_valid) begin
          out_inst       <= skid_inst;
          out_inst_valid <= 1'b1;
          out_inst_pc    <= skid_pc;
          out_next_pc    <= skid_pc + PC_WIDTH'(1);
          skid_valid     <= 1'b0;
        end else begin
          out_inst_valid <= 1'b0;
        end
      end
    end
  end

endmodule
